// File: rtl/rs232_tx_arbiter.sv
// Round-robin arbiter sharing one RS-232 transmitter between 2**IDX_W byte producers.
// Sequence per frame: capture byte (ACK), strobe send, wait finish or timeout, guard gap.
module rs232_tx_arbiter #(
  parameter int unsigned IDX_W       = 2,
  parameter int unsigned TIMEOUT_CLK = 200,
  parameter int unsigned GAP_CLK     = 2
) (
  input  logic                        clk_s,
  input  logic                        rst_s,
  input  logic [(1 << IDX_W)-1:0]     iREQ,
  input  logic [(1 << IDX_W)*8-1:0]   iDATA,
  output logic [(1 << IDX_W)-1:0]     oACK,
  output logic [(1 << IDX_W)-1:0]     oDONE,
  output logic                        oERR,
  output logic                        oSEND,
  output logic [7:0]                  oTXDATA,
  input  logic                        iFINISH,
  output logic                        oBUSY,
  output logic [IDX_W-1:0]            oGRANT
);

  localparam int unsigned N     = 1 << IDX_W;
  localparam int unsigned CNT_W = 18;
  localparam int unsigned GAP_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    BUSY = 2'd2,
    GAP  = 2'd3
  } state_t;

  state_t             state, state_n;
  logic [IDX_W-1:0]   ptr, ptr_n;
  logic [IDX_W-1:0]   grant_n;
  logic [7:0]         txdata_n;
  logic [N-1:0]       ack_n, done_n;
  logic               err_n, send_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [GAP_W-1:0]   gcnt, gcnt_n;
  logic               found;
  logic [IDX_W-1:0]   sel, cand;

  // State, pointer, counters and all registered outputs
  always_ff @(posedge clk_s) begin
    if (rst_s) begin
      state   <= IDLE;
      ptr     <= '0;
      cnt     <= '0;
      gcnt    <= '0;
      oGRANT  <= '0;
      oTXDATA <= 8'hFF;
      oACK    <= '0;
      oDONE   <= '0;
      oERR    <= 1'b0;
      oSEND   <= 1'b0;
      oBUSY   <= 1'b0;
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      cnt     <= cnt_n;
      gcnt    <= gcnt_n;
      oGRANT  <= grant_n;
      oTXDATA <= txdata_n;
      oACK    <= ack_n;
      oDONE   <= done_n;
      oERR    <= err_n;
      oSEND   <= send_n;
      oBUSY   <= (state_n != IDLE);
    end
  end

  // Round-robin search, next state and next output values
  always_comb begin
    state_n  = state;
    ptr_n    = ptr;
    grant_n  = oGRANT;
    txdata_n = oTXDATA;
    ack_n    = '0;
    done_n   = '0;
    err_n    = 1'b0;
    send_n   = 1'b0;
    cnt_n    = cnt;
    gcnt_n   = gcnt;
    found    = 1'b0;
    sel      = '0;
    cand     = '0;

    // First requester at or after the pointer, wrapping modulo N
    for (int unsigned i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!found && iREQ[cand]) begin
        found = 1'b1;
        sel   = cand;
      end
    end

    case (state)
      IDLE: begin
        if (found) begin
          state_n    = SEND;
          grant_n    = sel;
          txdata_n   = iDATA[{sel, 3'b000} +: 8];
          ack_n[sel] = 1'b1;
        end
      end
      SEND: begin
        // Strobe is registered, so it is seen during the first BUSY cycle
        send_n  = 1'b1;
        cnt_n   = '0;
        state_n = BUSY;
      end
      BUSY: begin
        cnt_n = cnt + CNT_W'(1);
        if (iFINISH || (cnt == CNT_W'(TIMEOUT_CLK - 1))) begin
          done_n[oGRANT] = 1'b1;
          err_n          = !iFINISH;
          ptr_n          = oGRANT + IDX_W'(1);
          gcnt_n         = '0;
          state_n        = (GAP_CLK == 0) ? IDLE : GAP;
        end
      end
      GAP: begin
        if (gcnt == GAP_W'(GAP_CLK - 1)) begin
          state_n = IDLE;
        end else begin
          gcnt_n = gcnt + GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_rs232_tx_arbiter.sv
// Directed bench for rs232_tx_arbiter with hand-computed expectations.
module tb_rs232_tx_arbiter;

  localparam int IDX_W = 2;
  localparam int N     = 4;

  logic             clk_s = 1'b0;
  logic             rst_s;
  logic [N-1:0]     iREQ;
  logic [N*8-1:0]   iDATA;
  logic [N-1:0]     oACK, oDONE;
  logic             oERR, oSEND, oBUSY, iFINISH;
  logic [7:0]       oTXDATA;
  logic [IDX_W-1:0] oGRANT;

  int checks    = 0;
  int failures  = 0;
  int cyc       = 0;
  int last_send = 0;
  int prev_send = 0;

  rs232_tx_arbiter #(.IDX_W(2), .TIMEOUT_CLK(200), .GAP_CLK(2)) dut (
    .clk_s   (clk_s),
    .rst_s   (rst_s),
    .iREQ    (iREQ),
    .iDATA   (iDATA),
    .oACK    (oACK),
    .oDONE   (oDONE),
    .oERR    (oERR),
    .oSEND   (oSEND),
    .oTXDATA (oTXDATA),
    .iFINISH (iFINISH),
    .oBUSY   (oBUSY),
    .oGRANT  (oGRANT)
  );

  always #5 clk_s = ~clk_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance one edge and sample 1 time unit later; track send strobes
  task automatic tick();
    @(posedge clk_s);
    #1;
    cyc++;
    if (oSEND === 1'b1) begin
      prev_send = last_send;
      last_send = cyc;
      check("send_while_busy", 32'(oBUSY), 32'd1);
    end
  endtask

  // Serve one frame of requester idx: finish after k BUSY cycles, or let it time out
  task automatic serve(input int idx, input int k, input bit use_finish, input bit exp_err);
    int n;
    int s;
    logic [7:0] exp_byte;
    exp_byte = iDATA[idx*8 +: 8];
    n = 0;
    while (oACK == '0 && n < 50) begin
      tick();
      n++;
    end
    check("ack_mask", 32'(oACK), 32'(1 << idx));
    check("grant", 32'(oGRANT), 32'(idx));
    check("txdata_at_ack", 32'(oTXDATA), 32'(exp_byte));
    tick();
    check("send_pulse", 32'(oSEND), 32'd1);
    check("txdata_at_send", 32'(oTXDATA), 32'(exp_byte));
    s = cyc;
    if (use_finish) begin
      repeat (k) tick();
      check("no_early_done", 32'(oDONE), 32'd0);
      iFINISH = 1'b1;
      tick();
      iFINISH = 1'b0;
    end else begin
      n = 0;
      while (oDONE == '0 && n < 400) begin
        tick();
        n++;
      end
      check("timeout_latency", 32'(cyc - s), 32'd200);
    end
    check("done_mask", 32'(oDONE), 32'(1 << idx));
    check("err", 32'(oERR), 32'(exp_err));
  endtask

  initial begin
    int ks[5];
    int order[5];
    rst_s   = 1'b1;
    iREQ    = '0;
    iDATA   = 32'h44A5_2211;
    iFINISH = 1'b0;
    repeat (3) tick();
    check("rst_busy", 32'(oBUSY), 32'd0);
    check("rst_txdata", 32'(oTXDATA), 32'hFF);
    check("rst_grant", 32'(oGRANT), 32'd0);
    check("rst_ack", 32'(oACK), 32'd0);
    check("rst_send", 32'(oSEND), 32'd0);
    rst_s = 1'b0;
    tick();

    // 1: single request from requester 2
    iREQ = 4'b0100;
    tick();
    check("t1_ack", 32'(oACK), 32'b0100);
    check("t1_busy", 32'(oBUSY), 32'd1);
    iREQ = 4'b0000;
    tick();
    check("t1_send", 32'(oSEND), 32'd1);
    check("t1_txdata", 32'(oTXDATA), 32'hA5);
    tick();
    check("t1_send_once", 32'(oSEND), 32'd0);
    repeat (4) tick();
    iFINISH = 1'b1;
    tick();
    iFINISH = 1'b0;
    check("t1_done", 32'(oDONE), 32'b0100);
    check("t1_err", 32'(oERR), 32'd0);
    tick();
    check("t1_gap_busy", 32'(oBUSY), 32'd1);
    check("t1_done_once", 32'(oDONE), 32'd0);
    tick();
    check("t1_idle_busy", 32'(oBUSY), 32'd0);

    // 2: all requesting after reset: order 0,1,2,3,0 with fixed send spacing
    rst_s = 1'b1;
    tick();
    rst_s = 1'b0;
    iDATA = 32'h4433_2211;
    iREQ  = 4'b1111;
    ks    = '{6, 9, 3, 12, 6};
    order = '{0, 1, 2, 3, 0};
    for (int f = 0; f < 5; f++) begin
      serve(order[f], ks[f], 1'b1, 1'b0);
      if (f > 0) check("t2_spacing", 32'(last_send - prev_send), 32'(ks[f-1] + 5));
    end

    // 3: grant 1, then 1011 wraps the pointer 3 -> 0 -> 1
    iREQ = 4'b0010;
    serve(1, 4, 1'b1, 1'b0);
    iREQ = 4'b1011;
    serve(3, 4, 1'b1, 1'b0);
    serve(0, 4, 1'b1, 1'b0);
    serve(1, 4, 1'b1, 1'b0);

    // 4: missing finish times out, next request served normally
    iREQ = 4'b0100;
    serve(2, 0, 1'b0, 1'b1);
    iREQ = 4'b1000;
    serve(3, 5, 1'b1, 1'b0);
    iREQ = 4'b0000;

    // 5: finish ignored in GAP and IDLE; finish on the timeout cycle wins
    iFINISH = 1'b1;
    tick();
    iFINISH = 1'b0;
    check("t5_gap_no_done", 32'(oDONE), 32'd0);
    check("t5_gap_busy", 32'(oBUSY), 32'd1);
    tick();
    check("t5_idle", 32'(oBUSY), 32'd0);
    iFINISH = 1'b1;
    tick();
    iFINISH = 1'b0;
    check("t5_idle_no_done", 32'(oDONE), 32'd0);
    check("t5_idle_stays", 32'(oBUSY), 32'd0);
    check("t5_idle_no_err", 32'(oERR), 32'd0);
    iREQ = 4'b0001;
    serve(0, 199, 1'b1, 1'b0);
    iREQ = 4'b0000;
    repeat (3) tick();

    // 6: reset during BUSY abandons the frame
    iREQ = 4'b0100;
    tick();
    check("t6_ack", 32'(oACK), 32'b0100);
    iREQ = 4'b0000;
    repeat (4) tick();
    check("t6_in_busy", 32'(oBUSY), 32'd1);
    rst_s = 1'b1;
    iREQ  = 4'b0010;
    tick();
    check("t6_rst_busy", 32'(oBUSY), 32'd0);
    check("t6_rst_txdata", 32'(oTXDATA), 32'hFF);
    check("t6_rst_grant", 32'(oGRANT), 32'd0);
    check("t6_rst_done", 32'(oDONE), 32'd0);
    rst_s = 1'b0;
    tick();
    check("t6_ack_after_rst", 32'(oACK), 32'b0010);
    iREQ = 4'b0000;
    tick();
    check("t6_send_after_rst", 32'(oSEND), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
